// File: rtl/instr_reader_pkg.sv
// -----------------------------------------------------------------------------
// instr_reader_pkg
// Shared types for the instruction-register read sequencer: opcode, operand,
// address and instruction word layouts, the 64-bit signed result type, the
// reader FSM state enum, and small helpers used by the reader and its ALU.
// -----------------------------------------------------------------------------
package instr_reader_pkg;

  localparam int DEPTH = 32;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } reader_state_t;

  // Sign-extend a 32-bit operand to the 64-bit result width.
  function automatic result_t sext_operand(input operand_t v);
    return {{32{v[31]}}, v};
  endfunction

  // Next read address; the register file wraps from its last entry to 0.
  function automatic address_t next_ptr(input address_t p);
    if (p == address_t'(DEPTH - 1)) begin
      return 5'd0;
    end else begin
      return p + 5'd1;
    end
  endfunction

endpackage

// File: rtl/instr_reader_if.sv
// -----------------------------------------------------------------------------
// instr_reader_if
// Bundles the reader's control, register-file read port and result handshake.
//   master : the controller / consumer side (drives start, first_ptr, count,
//            instruction_word, result_ready).
//   slave  : the instr_reader side (drives read_pointer, result, result_valid,
//            div_by_zero, busy, done).
// -----------------------------------------------------------------------------
interface instr_reader_if;
  import instr_reader_pkg::*;

  logic         start;
  address_t     first_ptr;
  logic [5:0]   count;
  address_t     read_pointer;
  instruction_t instruction_word;
  result_t      result;
  logic         result_valid;
  logic         result_ready;
  logic         div_by_zero;
  logic         busy;
  logic         done;

  modport master (
    output start, first_ptr, count, instruction_word, result_ready,
    input  read_pointer, result, result_valid, div_by_zero, busy, done
  );

  modport slave (
    input  start, first_ptr, count, instruction_word, result_ready,
    output read_pointer, result, result_valid, div_by_zero, busy, done
  );

endinterface

// File: rtl/instr_reader_alu.sv
// -----------------------------------------------------------------------------
// instr_alu
// Purely combinational opcode evaluator. Operands are sign-extended to 64 bits
// before the operation, so MULT yields the full signed product.
//   i_instr        : instruction word (opcode + two signed operands)
//   o_result       : 64-bit signed result
//   o_div_by_zero  : DIV/MOD with op_b == 0 (result forced to 0)
// -----------------------------------------------------------------------------
module instr_alu
  import instr_reader_pkg::*;
(
  input  instruction_t i_instr,
  output result_t      o_result,
  output logic         o_div_by_zero
);

  result_t w_a;
  result_t w_b;
  logic    w_b_zero;

  assign w_a      = sext_operand(i_instr.op_a);
  assign w_b      = sext_operand(i_instr.op_b);
  assign w_b_zero = (i_instr.op_b == 32'sd0);

  // Opcode decode; SV signed '/' truncates toward zero and '%' takes the
  // dividend's sign, which is exactly the required DIV/MOD behaviour.
  always_comb begin
    o_result      = 64'sd0;
    o_div_by_zero = 1'b0;
    case (i_instr.opc)
      ZERO:  o_result = 64'sd0;
      PASSA: o_result = w_a;
      PASSB: o_result = w_b;
      ADD:   o_result = w_a + w_b;
      SUB:   o_result = w_a - w_b;
      MULT:  o_result = w_a * w_b;
      DIV: begin
        if (w_b_zero) begin
          o_result      = 64'sd0;
          o_div_by_zero = 1'b1;
        end else begin
          o_result      = w_a / w_b;
        end
      end
      MOD: begin
        if (w_b_zero) begin
          o_result      = 64'sd0;
          o_div_by_zero = 1'b1;
        end else begin
          o_result      = w_a % w_b;
        end
      end
      default: begin
        o_result      = 64'sd0;
        o_div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_reader.sv
// -----------------------------------------------------------------------------
// instr_reader
// Read-side sequencer for the instruction register. On start it walks
// read_pointer from first_ptr through count entries (wrapping at DEPTH-1),
// evaluates each instruction and offers the result on a valid/ready handshake.
//   clk      : clock, all state on posedge
//   reset_n  : asynchronous active-low reset
//   bus      : instr_reader_if.slave (control, read port, result handshake)
// -----------------------------------------------------------------------------
module instr_reader
  import instr_reader_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  instr_reader_if.slave  bus
);

  reader_state_t r_state;
  logic [5:0]    r_remaining;
  address_t      r_read_pointer;
  result_t       r_result;
  logic          r_result_valid;
  logic          r_div_by_zero;
  logic          r_busy;
  logic          r_done;

  result_t       w_alu_result;
  logic          w_alu_dbz;

  instr_alu u_alu (
    .i_instr       (bus.instruction_word),
    .o_result      (w_alu_result),
    .o_div_by_zero (w_alu_dbz)
  );

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_remaining    <= 6'd0;
      r_read_pointer <= 5'd0;
      r_result       <= 64'sd0;
      r_result_valid <= 1'b0;
      r_div_by_zero  <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless re-raised below.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.count != 6'd0) begin
              r_read_pointer <= bus.first_ptr;
              r_remaining    <= bus.count;
              r_busy         <= 1'b1;
              r_state        <= EXEC;
            end else begin
              // Empty sequence: acknowledge immediately, stay idle.
              r_done <= 1'b1;
            end
          end
        end
        EXEC: begin
          r_result       <= w_alu_result;
          r_div_by_zero  <= w_alu_dbz;
          r_result_valid <= 1'b1;
          r_state        <= HOLD;
        end
        HOLD: begin
          if (bus.result_ready) begin
            r_result_valid <= 1'b0;
            if (r_remaining == 6'd1) begin
              r_remaining <= 6'd0;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_remaining    <= r_remaining - 6'd1;
              r_read_pointer <= next_ptr(r_read_pointer);
              r_state        <= EXEC;
            end
          end
        end
        default: begin
          r_state        <= IDLE;
          r_remaining    <= 6'd0;
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_pointer = r_read_pointer;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.div_by_zero  = r_div_by_zero;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule
